// File: rtl/instruction_decode.sv
// instruction_decode: single-stage registered decoder for the 20-bit ISA.
// Splits the word into fields and control strobes, one cycle of latency.
module instruction_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] instruction,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [1:0]  rs_a,
    output logic [1:0]  rs_b,
    output logic [1:0]  rd,
    output logic [15:0] imm,
    output logic [3:0]  alu_op,
    output logic        use_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        illegal
);

    logic [5:0]  w_op;
    logic        w_valid;
    logic [5:0]  w_opcode;
    logic [1:0]  w_rs_a;
    logic [1:0]  w_rs_b;
    logic [1:0]  w_rd;
    logic [15:0] w_imm;
    logic [3:0]  w_alu_op;
    logic        w_use_imm;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jump;
    logic        w_illegal;

    logic        r_valid;
    logic [5:0]  r_opcode;
    logic [1:0]  r_rs_a;
    logic [1:0]  r_rs_b;
    logic [1:0]  r_rd;
    logic [15:0] r_imm;
    logic [3:0]  r_alu_op;
    logic        r_use_imm;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_branch;
    logic        r_jump;
    logic        r_illegal;

    assign w_op = instruction[19:14];

    // Combinational decode; an invalid slot decodes to all zeros.
    always_comb begin
        w_valid     = 1'b0;
        w_opcode    = 6'd0;
        w_rs_a      = 2'd0;
        w_rs_b      = 2'd0;
        w_rd        = 2'd0;
        w_imm       = 16'd0;
        w_alu_op    = 4'd0;
        w_use_imm   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        if (in_valid) begin
            w_valid  = 1'b1;
            w_opcode = w_op;
            case (w_op[5:4])
                2'b00: begin
                    w_rs_a      = instruction[13:12];
                    w_rs_b      = instruction[11:10];
                    w_rd        = instruction[9:8];
                    w_alu_op    = w_op[3:0];
                    w_reg_write = 1'b1;
                end
                2'b01: begin
                    w_rs_a = instruction[13:12];
                    w_rs_b = instruction[11:10];
                    w_imm  = {{6{instruction[9]}}, instruction[9:0]};
                    case (w_op[3:2])
                        2'b00: begin
                            w_rd        = instruction[11:10];
                            w_alu_op    = {2'b00, w_op[1:0]};
                            w_use_imm   = 1'b1;
                            w_reg_write = 1'b1;
                        end
                        2'b01: begin
                            w_branch = 1'b1;
                            w_alu_op = {2'b10, w_op[1:0]};
                        end
                        2'b10: begin
                            w_rd        = instruction[11:10];
                            w_mem_read  = 1'b1;
                            w_reg_write = 1'b1;
                            w_use_imm   = 1'b1;
                        end
                        default: begin
                            w_mem_write = 1'b1;
                            w_use_imm   = 1'b1;
                        end
                    endcase
                end
                2'b10: begin
                    if (w_op[3]) begin
                        w_rd        = instruction[13:12];
                        w_imm       = {{4{instruction[11]}}, instruction[11:0]};
                        w_reg_write = 1'b1;
                        w_use_imm   = 1'b1;
                        w_alu_op    = 4'hF;
                    end else begin
                        w_imm  = {2'b00, instruction[13:0]};
                        w_jump = 1'b1;
                    end
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Output registers: flush clears the slot, stall holds, else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            r_valid     <= 1'b0;
            r_opcode    <= 6'd0;
            r_rs_a      <= 2'd0;
            r_rs_b      <= 2'd0;
            r_rd        <= 2'd0;
            r_imm       <= 16'd0;
            r_alu_op    <= 4'd0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_valid     <= w_valid;
            r_opcode    <= w_opcode;
            r_rs_a      <= w_rs_a;
            r_rs_b      <= w_rs_b;
            r_rd        <= w_rd;
            r_imm       <= w_imm;
            r_alu_op    <= w_alu_op;
            r_use_imm   <= w_use_imm;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_branch    <= w_branch;
            r_jump      <= w_jump;
            r_illegal   <= w_illegal;
        end
    end

    assign out_valid = r_valid;
    assign opcode    = r_opcode;
    assign rs_a      = r_rs_a;
    assign rs_b      = r_rs_b;
    assign rd        = r_rd;
    assign imm       = r_imm;
    assign alu_op    = r_alu_op;
    assign use_imm   = r_use_imm;
    assign reg_write = r_reg_write;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign branch    = r_branch;
    assign jump      = r_jump;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed and random checks of instruction_decode
// against a behavioural decode model.
module tb_instruction_decode;

    logic        clk;
    logic        rst_n;
    logic [19:0] instruction;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [1:0]  rs_a;
    logic [1:0]  rs_b;
    logic [1:0]  rd;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;

    int n_pass = 0;
    int n_tot  = 0;
    logic [39:0] exp_r;
    logic [39:0] dut_vec;

    instruction_decode u_dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_valid(out_valid), .opcode(opcode), .rs_a(rs_a),
        .rs_b(rs_b), .rd(rd), .imm(imm), .alu_op(alu_op),
        .use_imm(use_imm), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_vec = {out_valid, opcode, rs_a, rs_b, rd, imm, alu_op,
                      use_imm, reg_write, mem_read, mem_write,
                      branch, jump, illegal};

    // Reference decode: classes picked by numeric opcode range.
    function automatic logic [39:0] ref_dec(input logic [19:0] ins,
                                            input logic v);
        int op, sub, lo, f10, f12;
        logic [1:0] a, b, d;
        logic [15:0] im;
        logic [3:0] alu;
        logic ui, rw, mr, mw, br, jp, il;
        a = 0; b = 0; d = 0; im = 0; alu = 0;
        ui = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; il = 0;
        if (!v) return 40'd0;
        op  = int'(ins[19:14]);
        f10 = int'(ins[9:0]);
        f12 = int'(ins[11:0]);
        if (op < 16) begin
            a = ins[13:12]; b = ins[11:10]; d = ins[9:8];
            alu = 4'(op); rw = 1;
        end else if (op < 32) begin
            sub = (op - 16) / 4;
            lo  = op % 4;
            a = ins[13:12]; b = ins[11:10];
            im = 16'(f10 >= 512 ? f10 - 1024 : f10);
            if (sub == 0) begin
                d = b; alu = 4'(lo); ui = 1; rw = 1;
            end else if (sub == 1) begin
                br = 1; alu = 4'(8 + lo);
            end else if (sub == 2) begin
                d = b; mr = 1; rw = 1; ui = 1;
            end else begin
                mw = 1; ui = 1;
            end
        end else if (op < 40) begin
            im = 16'(int'(ins[13:0])); jp = 1;
        end else if (op < 48) begin
            d = ins[13:12];
            im = 16'(f12 >= 2048 ? f12 - 4096 : f12);
            rw = 1; ui = 1; alu = 15;
        end else begin
            il = 1;
        end
        return {1'b1, 6'(op), a, b, d, im, alu, ui, rw, mr, mw, br, jp, il};
    endfunction

    task automatic chk(input string tag, input logic [39:0] got,
                       input logic [39:0] want);
        n_tot++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    task automatic step(input string tag, input logic [19:0] ins,
                        input logic v, input logic st, input logic fl);
        @(negedge clk);
        instruction = ins; in_valid = v; stall = st; flush = fl;
        @(posedge clk);
        if (fl) exp_r = 40'd0;
        else if (!st) exp_r = ref_dec(ins, v);
        #1 chk(tag, dut_vec, exp_r);
    endtask

    initial begin
        logic [19:0] w;
        rst_n = 1'b0; instruction = 20'd0; in_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; exp_r = 40'd0;
        #3 chk("reset", dut_vec, 40'd0);
        @(negedge clk); rst_n = 1'b1;

        // R-type
        step("rtype", {6'b000000, 2'd2, 2'd3, 2'd1, 8'h00}, 1, 0, 0);
        chk("rtype_fields", {40'(out_valid), 40'(rs_a), 40'(rs_b), 40'(rd)},
            {40'd1, 40'd2, 40'd3, 40'd1});

        // Asynchronous reset mid-cycle, held through release
        #2 rst_n = 1'b0;
        #1 chk("async_rst", dut_vec, 40'd0);
        exp_r = 40'd0;
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
        #1 chk("rst_release", dut_vec, 40'd0);

        // RI branch, positive and negative immediates
        step("branch", {6'b010101, 2'd0, 2'd2, 10'h0A8}, 1, 0, 0);
        chk("branch_imm", {24'd0, imm}, 40'h00A8);
        chk("branch_alu", {36'd0, alu_op}, 40'h9);
        step("branch_neg", {6'b010101, 2'd0, 2'd2, 10'h3F0}, 1, 0, 0);
        chk("branch_neg_imm", {24'd0, imm}, 40'hFFF0);

        // Other RI subclasses
        step("alui", {6'b010011, 2'd1, 2'd3, 10'h155}, 1, 0, 0);
        step("load", {6'b011010, 2'd3, 2'd1, 10'h200}, 1, 0, 0);
        step("store", {6'b011101, 2'd2, 2'd0, 10'h07F}, 1, 0, 0);

        // Immediate injection
        step("inject", {6'b101010, 2'd2, 12'hFB8}, 1, 0, 0);
        chk("inject_imm", {24'd0, imm}, 40'hFFB8);
        chk("inject_ctl", {36'd0, alu_op}, 40'hF);

        // Jump then reserved
        step("jump", {6'b100000, 11'h0C3, 3'b000}, 1, 0, 0);
        chk("jump_imm", {24'd0, imm}, 40'h0618);
        step("reserved", {6'b110000, 14'h3ABC}, 1, 0, 0);
        chk("reserved_ill", {33'd0, illegal, reg_write, mem_read,
                             mem_write, branch, jump, use_imm},
            40'b1000000);

        // Stall holds, flush beats stall, invalid clears
        step("load_r", {6'b001100, 2'd1, 2'd2, 2'd3, 8'hFF}, 1, 0, 0);
        step("stall", {6'b101000, 2'd0, 12'h123}, 1, 1, 0);
        chk("stall_rd", {38'd0, rd}, 40'd3);
        step("stall_flush", {6'b101000, 2'd0, 12'h123}, 1, 1, 1);
        chk("flush_valid", {39'd0, out_valid}, 40'd0);
        step("load_j", {6'b100111, 14'h1234}, 1, 0, 0);
        step("invalid", {6'b000001, 14'h3FFF}, 0, 0, 0);
        chk("invalid_valid", {39'd0, out_valid}, 40'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            w = 20'($urandom);
            step("random", w, ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
